// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier producing the full 2*WIDTH-bit product of two
// WIDTH-bit operands, unsigned or two's-complement, one partial product per cycle.
module seq_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 iStart,
  input  logic                 iSigned,
  input  logic [WIDTH-1:0]     iA,
  input  logic [WIDTH-1:0]     iB,
  output logic                 oBusy,
  output logic                 oDone,
  output logic [2*WIDTH-1:0]   oResult,
  output logic                 oFits
);

  localparam int CNT_W  = $clog2(WIDTH + 1);
  localparam int PROD_W = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t              state;
  state_t              stateNext;

  logic                signedMode;
  logic                resSign;
  logic [WIDTH-1:0]    mcand;
  logic [WIDTH-1:0]    mplier;
  logic [PROD_W-1:0]   acc;
  logic [CNT_W-1:0]    cnt;
  logic                lastIter;
  logic [PROD_W-1:0]   fixedProd;

  // Most-negative input maps to 2^(WIDTH-1), which still fits the unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] value,
                                                 input logic             isSigned);
    logic signed [WIDTH-1:0] sv;
    sv = signed'(value);
    if (isSigned && (sv < 0))
      magnitude = unsigned'(-sv);
    else
      magnitude = value;
  endfunction

  function automatic logic [PROD_W-1:0] applySign(input logic [PROD_W-1:0] value,
                                                  input logic              negate);
    logic signed [PROD_W-1:0] sv;
    sv = signed'(value);
    if (negate)
      applySign = unsigned'(-sv);
    else
      applySign = value;
  endfunction

  function automatic logic fitsIn(input logic [PROD_W-1:0] value,
                                  input logic              isSigned);
    logic [WIDTH-1:0] upper;
    upper = value[PROD_W-1:WIDTH];
    if (isSigned)
      fitsIn = (upper == {WIDTH{value[WIDTH-1]}});
    else
      fitsIn = (upper == '0);
  endfunction

  assign lastIter  = (cnt == CNT_W'(WIDTH - 1));
  assign fixedProd = applySign(acc, resSign);
  assign oBusy     = (state != IDLE);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)
      state <= IDLE;
    else
      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (iStart) stateNext = CALC;
      CALC:    if (lastIter) stateNext = FIX;
      FIX:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Capture at start, one conditional add per CALC cycle, sign fix-up in FIX.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      signedMode <= 1'b0;
      resSign    <= 1'b0;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      cnt        <= '0;
      oResult    <= '0;
      oFits      <= 1'b1;
      oDone      <= 1'b0;
    end else begin
      oDone <= 1'b0;
      case (state)
        IDLE: begin
          if (iStart) begin
            signedMode <= iSigned;
            mcand      <= magnitude(iA, iSigned);
            mplier     <= magnitude(iB, iSigned);
            resSign    <= iSigned & (iA[WIDTH-1] ^ iB[WIDTH-1]);
            acc        <= '0;
            cnt        <= '0;
          end
        end
        CALC: begin
          if (mplier[0])
            acc <= acc + (PROD_W'(mcand) << cnt);
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
        end
        FIX: begin
          oResult <= fixedProd;
          oFits   <= fitsIn(fixedProd, signedMode);
          oDone   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: WIDTH=16 and WIDTH=4 instances sharing clock and reset.
module tb_seq_multiplier;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;

  logic        iStart16 = 1'b0, iSigned16 = 1'b0;
  logic [15:0] iA16 = '0, iB16 = '0;
  logic        oBusy16, oDone16, oFits16;
  logic [31:0] oResult16;

  logic        iStart4 = 1'b0, iSigned4 = 1'b0;
  logic [3:0]  iA4 = '0, iB4 = '0;
  logic        oBusy4, oDone4, oFits4;
  logic [7:0]  oResult4;

  int nCompared = 0;
  int nMismatched = 0;

  seq_multiplier #(.WIDTH(16)) dut16 (
    .Clock(Clock), .Reset(Reset), .iStart(iStart16), .iSigned(iSigned16),
    .iA(iA16), .iB(iB16), .oBusy(oBusy16), .oDone(oDone16),
    .oResult(oResult16), .oFits(oFits16)
  );

  seq_multiplier #(.WIDTH(4)) dut4 (
    .Clock(Clock), .Reset(Reset), .iStart(iStart4), .iSigned(iSigned4),
    .iA(iA4), .iB(iB4), .oBusy(oBusy4), .oDone(oDone4),
    .oResult(oResult4), .oFits(oFits4)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive16(input logic sgn, input logic [15:0] a, input logic [15:0] b);
    iSigned16 = sgn;
    iA16      = a;
    iB16      = b;
    iStart16  = 1'b1;
  endtask

  // Acceptance edge is the next posedge; returns #1 after the done edge.
  task automatic run16(input string tag, input logic [31:0] expRes, input logic expFits,
                       input bit pokeAt5);
    int  n;
    bit  busyOk;
    @(posedge Clock); #1;
    iStart16  = 1'b0;
    iA16      = 16'h5A5A;
    iB16      = 16'hA5A5;
    iSigned16 = ~iSigned16;
    busyOk    = oBusy16;
    n = 0;
    while (n < 40 && !oDone16) begin
      if (pokeAt5 && n == 4) begin
        iA16 = 16'h1234; iB16 = 16'h0010; iStart16 = 1'b1;
      end
      @(posedge Clock); #1;
      n++;
      iStart16 = 1'b0;
      if (!oDone16 && !oBusy16) busyOk = 1'b0;
    end
    chk({tag, ".latency"}, 64'(n), 64'd17);
    chk({tag, ".busyHeld"}, 64'(busyOk), 64'd1);
    chk({tag, ".busyFell"}, 64'(oBusy16), 64'd0);
    chk({tag, ".result"}, 64'(oResult16), 64'(expRes));
    chk({tag, ".fits"}, 64'(oFits16), 64'(expFits));
  endtask

  task automatic run4(input string tag, input logic sgn, input logic [3:0] a,
                      input logic [3:0] b, input logic [7:0] expRes, input logic expFits);
    int n;
    iSigned4 = sgn; iA4 = a; iB4 = b; iStart4 = 1'b1;
    @(posedge Clock); #1;
    iStart4 = 1'b0; iA4 = 4'h0; iB4 = 4'h0;
    n = 0;
    while (n < 20 && !oDone4) begin
      @(posedge Clock); #1;
      n++;
    end
    chk({tag, ".latency"}, 64'(n), 64'd5);
    chk({tag, ".result"}, 64'(oResult4), 64'(expRes));
    chk({tag, ".fits"}, 64'(oFits4), 64'(expFits));
  endtask

  initial begin
    bit sawDone;

    #12;
    chk("rst.busy", 64'(oBusy16), 64'd0);
    chk("rst.done", 64'(oDone16), 64'd0);
    chk("rst.result", 64'(oResult16), 64'd0);
    chk("rst.fits", 64'(oFits16), 64'd1);
    chk("rst.result4", 64'(oResult4), 64'd0);
    @(negedge Clock);
    Reset = 1'b1;
    @(posedge Clock); #1;

    drive16(1'b0, 16'h000C, 16'h000D);
    run16("u12x13", 32'h0000009C, 1'b1, 1'b0);
    drive16(1'b0, 16'hFFFF, 16'hFFFF);
    run16("uFFFFsq", 32'hFFFE0001, 1'b0, 1'b0);
    drive16(1'b1, 16'hFFFF, 16'hFFFF);
    run16("sM1xM1", 32'h00000001, 1'b1, 1'b0);
    drive16(1'b1, 16'h8000, 16'h8000);
    run16("sMinSq", 32'h40000000, 1'b0, 1'b0);
    drive16(1'b1, 16'hFFFF, 16'h0003);
    run16("sM1x3", 32'hFFFFFFFD, 1'b1, 1'b0);
    drive16(1'b1, 16'h7FFF, 16'h8000);
    run16("sMaxMin", 32'hC0008000, 1'b0, 1'b0);

    // Start while busy is ignored; then a start in the done cycle is accepted.
    drive16(1'b0, 16'h0003, 16'h0007);
    run16("poke", 32'h00000015, 1'b1, 1'b1);
    drive16(1'b0, 16'h0100, 16'h0100);
    run16("b2b", 32'h00010000, 1'b0, 1'b0);
    @(posedge Clock); #1;
    chk("doneOnce", 64'(oDone16), 64'd0);
    chk("idleAfter", 64'(oBusy16), 64'd0);

    // Asynchronous reset in the middle of a product.
    drive16(1'b0, 16'h00FF, 16'h00FF);
    @(posedge Clock); #1;
    iStart16 = 1'b0;
    repeat (8) @(posedge Clock);
    #3 Reset = 1'b0;
    #1;
    chk("midRst.busy", 64'(oBusy16), 64'd0);
    chk("midRst.done", 64'(oDone16), 64'd0);
    chk("midRst.result", 64'(oResult16), 64'd0);
    @(negedge Clock);
    Reset = 1'b1;
    sawDone = 1'b0;
    repeat (25) begin
      @(posedge Clock); #1;
      if (oDone16) sawDone = 1'b1;
    end
    chk("midRst.noDone", 64'(sawDone), 64'd0);
    drive16(1'b0, 16'h0003, 16'h0005);
    run16("u3x5", 32'h0000000F, 1'b1, 1'b0);

    run4("w4uFxF", 1'b0, 4'hF, 4'hF, 8'hE1, 1'b0);
    run4("w4sM8x7", 1'b1, 4'h8, 4'h7, 8'hC8, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
